// File: rtl/seq_engine_pkg.sv
// Shared state encoding and default widths for seq_engine.
package seq_engine_pkg;

  localparam int unsigned PROG_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIB   = 2'b01,
    TIMER = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/clk_div_en.sv
// Programmable tick generator: one-cycle tick every 2^(prog_q+1) clocks,
// restarted from zero by clear.
module clk_div_en #(
  parameter int unsigned PROG_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROG_W-1:0] prog_q,
  output logic              tick
);

  localparam int unsigned CNT_W = 1 << PROG_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   span_c;

  // Period is one bit wider than the counter so prog_q = max does not overflow.
  assign span_c = (CNT_W+1)'(2) << prog_q;
  assign tick   = (cnt_q == CNT_W'(span_c - (CNT_W+1)'(1)));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_engine.sv
// Fibonacci / timer sequence engine paced by clk_div_en.
// Optional registered parity output: define SEQ_ENGINE_PARITY_EN.
module seq_engine
  import seq_engine_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PROG_W    = PROG_W_DEF,
  parameter int unsigned TIMER_MAX = 50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              parity,
  output logic [1:0]        state,
  output logic              done
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PROG_W-1:0] prog_q;
  logic              valid_q, valid_d;
  logic              done_q;
  logic              last_q, last_d;
  logic              start_c, clear_c, tick_c;
  logic [WIDTH:0]    sum_c;
  logic [WIDTH-1:0]  inc_c;

  assign start_c = (state_q == IDLE) && (start_f || start_t);
  assign clear_c = start_c || update;
  assign sum_c   = {1'b0, a_q} + {1'b0, b_q};
  assign inc_c   = data_out_q + WIDTH'(1);

  clk_div_en #(.PROG_W(PROG_W)) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear_c),
    .prog_q (prog_q),
    .tick   (tick_c)
  );

  // last_q marks that the final term was just emitted; DONE follows one edge later.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    a_d        = a_q;
    b_d        = b_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d    = start_f ? FIB : TIMER;
          data_out_d = '0;
          a_d        = '0;
          b_d        = WIDTH'(1);
        end
      end
      FIB: begin
        if (stop_f_t) begin
          state_d = IDLE;
        end else if (last_q) begin
          state_d = DONE;
        end else if (tick_c) begin
          data_out_d = b_q;
          valid_d    = 1'b1;
          if (sum_c[WIDTH]) begin
            last_d = 1'b1;
          end else begin
            a_d = b_q;
            b_d = sum_c[WIDTH-1:0];
          end
        end
      end
      TIMER: begin
        if (stop_f_t) begin
          state_d = IDLE;
        end else if (last_q) begin
          state_d = DONE;
        end else if (tick_c) begin
          data_out_d = inc_c;
          valid_d    = 1'b1;
          last_d     = (inc_c == WIDTH'(TIMER_MAX));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      data_out_q <= '0;
      a_q        <= '0;
      b_q        <= WIDTH'(1);
      prog_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      a_q        <= a_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      done_q     <= (state_d == DONE);
      last_q     <= last_d;
      if (update) prog_q <= prog;
    end
  end

`ifdef SEQ_ENGINE_PARITY_EN
  logic parity_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) parity_q <= 1'b0;
    else        parity_q <= ^data_out_d;
  end
  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_engine.sv
// Self-checking bench for seq_engine: scenario table, corner sequences and
// random traffic against a term-list reference model.
module tb_seq_engine;

  localparam int W  = 8;
  localparam int PW = 3;
  localparam int TM = 5;

  logic          clk, rst_n;
  logic          start_f, start_t, stop_f_t, update;
  logic [PW-1:0] prog;
  logic [W-1:0]  data_out;
  logic          data_valid, parity, done;
  logic [1:0]    state;

  seq_engine #(.WIDTH(W), .PROG_W(PW), .TIMER_MAX(TM)) dut (
    .clock(clk), .reset(rst_n), .start_f(start_f), .start_t(start_t),
    .stop_f_t(stop_f_t), .update(update), .prog(prog),
    .data_out(data_out), .data_valid(data_valid), .parity(parity),
    .state(state), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errs = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 fib, 2 timer, 3 done.
  int     m_mode, m_age, m_prog, m_idx, m_out;
  bit     m_valid, m_done, m_pend;
  int     m_terms[$];

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_prog = 0; m_idx = 0; m_out = 0;
    m_valid = 0; m_done = 0; m_pend = 0;
    m_terms.delete();
  endtask

  function automatic bit model_tick_now();
    int period = 1 << (m_prog + 1);
    return ((m_age + 1) % period) == 0;
  endfunction

  task automatic build_terms(bit fib);
    int a, b, t;
    m_terms.delete();
    if (fib) begin
      a = 0; b = 1;
      forever begin
        m_terms.push_back(b);
        if (a + b > (1 << W) - 1) break;
        t = a + b; a = b; b = t;
      end
    end else begin
      for (int i = 1; i <= TM; i++) m_terms.push_back(i);
    end
  endtask

  task automatic model_step(bit sf, bit st, bit stp, bit upd, int prg);
    bit tick = model_tick_now();
    bit clr  = upd;
    m_valid = 0;
    case (m_mode)
      0: if (sf || st) begin
        clr = 1; m_out = 0; m_mode = sf ? 1 : 2;
        build_terms(sf); m_idx = 0; m_pend = 0;
      end
      1, 2: begin
        if (stp) m_mode = 0;
        else if (m_pend) m_mode = 3;
        else if (tick) begin
          m_out = m_terms[m_idx]; m_idx++; m_valid = 1;
          if (m_idx == m_terms.size()) m_pend = 1;
        end
      end
      default: m_mode = 0;
    endcase
    m_done = (m_mode == 3);
    m_age  = clr ? 0 : m_age + 1;
    if (upd) m_prog = prg;
  endtask

  function automatic logic [12:0] expected_vec();
    logic [W-1:0] o = W'(m_out);
    logic p;
`ifdef SEQ_ENGINE_PARITY_EN
    p = ^o;
`else
    p = 1'b0;
`endif
    return {2'(m_mode), m_done, m_valid, p, o};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(string name);
    logic [12:0] act = {state, done, data_valid, parity, data_out};
    check(name, int'(act), int'(expected_vec()));
  endtask

  task automatic cycle(string name = "cyc");
    model_step(start_f, start_t, stop_f_t, update, int'(prog));
    @(posedge clk); #1;
    check_outputs(name);
    start_f = 0; start_t = 0; stop_f_t = 0; update = 0;
  endtask

  typedef struct {
    int prog; bit sf; bit st; int stop_tick;
    int exp_cnt; int exp_last; int exp_lat; int exp_done; int exp_st;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(int k, vec_t v);
    int nval = 0, ndone = 0, lat = -1, last = -1, c, st_seen;
    update = 1; prog = PW'(v.prog); cycle("upd");
    start_f = v.sf; start_t = v.st; cycle("start");
    st_seen = int'(state);
    for (c = 1; c <= 4000; c++) begin
      if (v.stop_tick != 0 && nval == v.stop_tick - 1 && model_tick_now()) stop_f_t = 1;
      cycle("run");
      if (data_valid) begin
        nval++; last = int'(data_out);
        if (lat < 0) lat = c;
      end
      if (done) ndone++;
      if (m_mode == 0) break;
    end
    if (c > 4000) check($sformatf("v%0d_timeout", k), c, 0);
    check($sformatf("v%0d_state", k), st_seen, v.exp_st);
    check($sformatf("v%0d_count", k), nval, v.exp_cnt);
    check($sformatf("v%0d_last", k), last, v.exp_last);
    check($sformatf("v%0d_latency", k), lat, v.exp_lat);
    check($sformatf("v%0d_done", k), ndone, v.exp_done);
    repeat (3) cycle("hold");
  endtask

  initial begin
    int n;
    vecs[0] = '{3, 1, 0, 0, 13, 233, 16, 1, 1};
    vecs[1] = '{0, 0, 1, 0,  5,   5,  2, 1, 2};
    vecs[2] = '{1, 0, 1, 0,  5,   5,  4, 1, 2};
    vecs[3] = '{0, 1, 1, 0, 13, 233,  2, 1, 1};
    vecs[4] = '{0, 0, 1, 3,  2,   2,  2, 0, 2};
    vecs[5] = '{2, 1, 0, 5,  4,   3,  8, 0, 1};

    start_f = 0; start_t = 0; stop_f_t = 0; update = 0; prog = '0;
    rst_n = 0;
    model_reset();
    #1 check_outputs("reset_state");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    repeat (2) cycle("idle");

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // Coincident starts, ignored start_t, then a mid-run reprogram.
    update = 1; prog = 3'd2; cycle("upd2");
    start_f = 1; start_t = 1; cycle("both");
    check("both_state", int'(state), 1);
    repeat (3) cycle("fib");
    start_t = 1; cycle("ign_start");
    repeat (5) cycle("fib");
    update = 1; prog = 3'd1; cycle("upd_mid");
    n = 0;
    while (!data_valid && n < 20) begin cycle("wait_tick"); n++; end
    check("upd_tick_latency", n, 4);
    stop_f_t = 1; cycle("stop");
    repeat (2) cycle("idle");

    // Asynchronous reset in the middle of a Fibonacci run.
    update = 1; prog = 3'd0; cycle("upd0");
    start_f = 1; cycle("start_fib");
    repeat (10) cycle("fib");
    #2 rst_n = 0;
    model_reset();
    #1 check("async_reset", int'({state, done, data_valid, parity, data_out}), 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (5) cycle("post_reset");
    check("post_reset_state", int'(state), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start_f  = ($urandom % 40) == 0;
      start_t  = ($urandom % 40) == 0;
      stop_f_t = ($urandom % 25) == 0;
      update   = ($urandom % 60) == 0;
      prog     = PW'($urandom_range(0, 2));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
